// File: rtl/drv_segment_hex_mux_pkg.sv
// Shared segment encoding for the multiplexed hex display driver.
// Segment vectors are active-low, bit0=a ... bit6=g.
package pkg_segment;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b1111111;

   localparam seg_t SEG_TABLE [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/drv_segment_hex_dec.sv
// Hex nibble to active-low seven-segment pattern (pure combinational lookup).
module drv_segment_hex_dec
   import pkg_segment::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_sgmnt
);

   assign o_sgmnt = SEG_TABLE[i_hex];

endmodule

// File: rtl/drv_segment_hex_mux.sv
// Time-multiplexed hex display driver: shadow registers, slot prescaler,
// digit scan with anti-ghost dark interval, optional leading-zero blanking.
// Every pin is a flop fed from the current prescaler/index state.
module drv_segment_hex_mux
   import pkg_segment::*;
#(
   parameter int DIGITS      = 4,
   parameter int SCAN_DIV    = 50000,
   parameter int GHOST_CYC   = 2,
   parameter int LZ_SUPPRESS = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [4*DIGITS-1:0]   i_value,
   input  logic [DIGITS-1:0]     i_dp,
   input  logic [DIGITS-1:0]     i_blank,
   input  logic                  i_load,
   output logic [6:0]            o_drv_sgmnt,
   output logic                  o_drv_dp,
   output logic [DIGITS-1:0]     o_drv_anode,
   output logic                  o_frame
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] P_GHOST = PW'(GHOST_CYC);
   localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);

   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_value;
   logic [DIGITS-1:0]   r_dp;
   logic [DIGITS-1:0]   r_blank;

   logic [6:0]          r_sgmnt;
   logic                r_dp_out;
   logic [DIGITS-1:0]   r_anode;
   logic                r_frame;

   logic                w_wrap;
   logic                w_dark;
   logic [3:0]          w_nib;
   logic                w_dp_req;
   logic                w_forced;
   logic                w_supp;
   logic [DIGITS-1:0]   w_anode_on;
   logic [DIGITS-1:0]   w_lz;
   logic [6:0]          w_seg;

   // Shadow capture of the display contents; blanked until first load.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_value <= '0;
         r_dp    <= '0;
         r_blank <= '1;
      end else if (i_load) begin
         r_value <= i_value;
         r_dp    <= i_dp;
         r_blank <= i_blank;
      end
   end

   // Slot prescaler and digit index; index steps on the prescaler terminal count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (r_presc == P_LAST) begin
         r_presc <= '0;
         r_idx   <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   assign w_wrap = (r_presc == P_LAST) && (r_idx == I_LAST);
   assign w_dark = (r_presc < P_GHOST);

   // Leading-zero map and selection of the current digit's shadow fields.
   always_comb begin
      logic v_run;
      v_run      = 1'b1;
      w_lz       = '0;
      w_nib      = '0;
      w_dp_req   = 1'b0;
      w_forced   = 1'b0;
      w_supp     = 1'b0;
      w_anode_on = '1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         v_run = v_run & (r_value[4*k +: 4] == 4'h0);
         w_lz[k] = (LZ_SUPPRESS != 0) && (k > 0) && v_run;
      end
      for (int k = 0; k < DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_nib         = r_value[4*k +: 4];
            w_dp_req      = r_dp[k];
            w_forced      = r_blank[k];
            w_supp        = w_lz[k];
            w_anode_on[k] = 1'b0;
         end
      end
   end

   drv_segment_hex_dec u_dec (
      .i_hex   (w_nib),
      .o_sgmnt (w_seg)
   );

   // Output registers; reset darkens the display without waiting for a clock.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_anode  <= '1;
         r_sgmnt  <= SEG_BLANK;
         r_dp_out <= 1'b1;
         r_frame  <= 1'b0;
      end else begin
         r_frame <= w_wrap;
         if (w_dark) begin
            r_anode  <= '1;
            r_sgmnt  <= SEG_BLANK;
            r_dp_out <= 1'b1;
         end else begin
            r_anode  <= w_anode_on;
            r_sgmnt  <= (w_forced || w_supp) ? SEG_BLANK : w_seg;
            r_dp_out <= ~(w_dp_req & ~w_forced);
         end
      end
   end

   assign o_drv_sgmnt = r_sgmnt;
   assign o_drv_dp    = r_dp_out;
   assign o_drv_anode = r_anode;
   assign o_frame     = r_frame;

endmodule

// File: tb/tb_drv_segment_hex_mux.sv
// Bench for drv_segment_hex_mux with DIGITS=4, SCAN_DIV=8, GHOST_CYC=2.
// Two instances share stimulus: one plain, one with leading-zero suppression.
module tb_drv_segment_hex_mux;

   localparam int DIGITS = 4;
   localparam int SDIV   = 8;
   localparam int GHOST  = 2;

   // ---------------- clock / reset ----------------
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [15:0] i_value = '0;
   logic [3:0]  i_dp = '0;
   logic [3:0]  i_blank = '0;
   logic        i_load = 1'b0;

   logic [6:0]  o_sg_a, o_sg_b;
   logic        o_dp_a, o_dp_b;
   logic [3:0]  o_an_a, o_an_b;
   logic        o_fr_a, o_fr_b;

   always #5 i_clk = ~i_clk;

   drv_segment_hex_mux #(.DIGITS(DIGITS), .SCAN_DIV(SDIV), .GHOST_CYC(GHOST), .LZ_SUPPRESS(0)) u_dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_value(i_value), .i_dp(i_dp), .i_blank(i_blank),
      .i_load(i_load), .o_drv_sgmnt(o_sg_a), .o_drv_dp(o_dp_a), .o_drv_anode(o_an_a),
      .o_frame(o_fr_a)
   );

   drv_segment_hex_mux #(.DIGITS(DIGITS), .SCAN_DIV(SDIV), .GHOST_CYC(GHOST), .LZ_SUPPRESS(1)) u_dut_lz (
      .i_clk(i_clk), .i_rst(i_rst), .i_value(i_value), .i_dp(i_dp), .i_blank(i_blank),
      .i_load(i_load), .o_drv_sgmnt(o_sg_b), .o_drv_dp(o_dp_b), .o_drv_anode(o_an_b),
      .o_frame(o_fr_b)
   );

   // ---------------- reference model ----------------
   logic [6:0] seg_rom [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic [3:0]  m_blank;
   int          cyc;       // slot position reflected by the next sampled outputs
   int          n_pass = 0;
   int          n_total = 0;

   localparam logic [12:0] IDLE = {4'hF, 7'h7F, 1'b1, 1'b0};

   // Outputs {anode, segments, dp, frame} for scan position s since reset release.
   function automatic logic [12:0] model(int s, logic [15:0] v, logic [3:0] dpv,
                                         logic [3:0] bl, bit lz);
      int          p;
      int          d;
      logic [3:0]  an;
      logic [6:0]  sg;
      logic        dpo;
      logic        fr;
      logic [15:0] upper;
      logic [3:0]  nib;
      bit          supp;
      p     = s % SDIV;
      d     = (s / SDIV) % DIGITS;
      fr    = ((s % (SDIV * DIGITS)) == (SDIV * DIGITS - 1));
      an    = 4'hF;
      sg    = 7'h7F;
      dpo   = 1'b1;
      if (p >= GHOST) begin
         upper = v >> (4 * d);
         nib   = upper[3:0];
         supp  = lz && (d > 0) && (upper == 16'h0);
         an[d] = 1'b0;
         sg    = (bl[d] || supp) ? 7'h7F : seg_rom[nib];
         dpo   = !(dpv[d] && !bl[d]);
      end
      return {an, sg, dpo, fr};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic model_reset();
      m_val   = '0;
      m_dp    = '0;
      m_blank = '1;
      cyc     = 0;
   endtask

   // One clock: predict from pre-edge shadows, apply load to model, compare after edge.
   task automatic step();
      logic [12:0] ea;
      logic [12:0] eb;
      ea = model(cyc, m_val, m_dp, m_blank, 1'b0);
      eb = model(cyc, m_val, m_dp, m_blank, 1'b1);
      if (i_load) begin
         m_val   = i_value;
         m_dp    = i_dp;
         m_blank = i_blank;
      end
      @(posedge i_clk);
      #1;
      check("scan", {o_an_a, o_sg_a, o_dp_a, o_fr_a}, ea);
      check("scan_lz", {o_an_b, o_sg_b, o_dp_b, o_fr_b}, eb);
      cyc++;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic [27:0] seg;     // expected lit segments, digit k at [7k +: 7]
      logic [27:0] seg_lz;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int s;
      int d;
      vecs[0] = '{16'h1234, 4'h0, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
      vecs[1] = '{16'h00A0, 4'h0, 4'h0, {7'h40, 7'h40, 7'h08, 7'h40}, {7'h7F, 7'h7F, 7'h08, 7'h40}};
      vecs[2] = '{16'h5678, 4'h4, 4'h4, {7'h12, 7'h7F, 7'h78, 7'h00}, {7'h12, 7'h7F, 7'h78, 7'h00}};
      vecs[3] = '{16'h0000, 4'hF, 4'h0, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vecs[4] = '{16'hBCDE, 4'h0, 4'h9, {7'h7F, 7'h46, 7'h21, 7'h7F}, {7'h7F, 7'h46, 7'h21, 7'h7F}};

      // Reset state while reset is held.
      model_reset();
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_out", {o_an_a, o_sg_a, o_dp_a, o_fr_a}, IDLE);
      check("reset_out_lz", {o_an_b, o_sg_b, o_dp_b, o_fr_b}, IDLE);
      i_rst = 1'b0;

      // Table: load, align to a frame, scan one frame and check mid-slot segments.
      for (int v = 0; v < 5; v++) begin
         i_value = vecs[v].value;
         i_dp    = vecs[v].dp;
         i_blank = vecs[v].blank;
         i_load  = 1'b1;
         step();
         i_load  = 1'b0;
         while ((cyc % (SDIV * DIGITS)) != 0) step();
         for (int n = 0; n < SDIV * DIGITS; n++) begin
            step();
            s = cyc - 1;
            if ((s % SDIV) == 4) begin
               d = (s / SDIV) % DIGITS;
               check("vec_seg", {6'd0, o_sg_a}, {6'd0, vecs[v].seg[7*d +: 7]});
               check("vec_seg_lz", {6'd0, o_sg_b}, {6'd0, vecs[v].seg_lz[7*d +: 7]});
            end
         end
      end

      // Load on the terminal prescaler cycle of digit 0: digit 1 shows it when first lit.
      while ((cyc % (SDIV * DIGITS)) != SDIV - 1) step();
      i_value = 16'hFFFF;
      i_dp    = 4'h0;
      i_blank = 4'h0;
      i_load  = 1'b1;
      step();
      i_load  = 1'b0;
      while ((cyc % (SDIV * DIGITS)) != SDIV + GHOST + 1) step();
      check("switch_load", {2'd0, o_an_a, o_sg_a}, {2'd0, 4'b1101, 7'h0E});

      // Reset mid-slot of digit 2: dark at once, then restart at digit 0.
      while ((cyc % (SDIV * DIGITS)) != 2 * SDIV + 3) step();
      #2;
      i_rst = 1'b1;
      #1;
      check("async_rst", {o_an_a, o_sg_a, o_dp_a, o_fr_a}, IDLE);
      check("async_rst_lz", {o_an_b, o_sg_b, o_dp_b, o_fr_b}, IDLE);
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_hold", {o_an_a, o_sg_a, o_dp_a, o_fr_a}, IDLE);
      i_rst = 1'b0;
      model_reset();
      step();
      step();
      check("post_rst_dark", {9'd0, o_an_a}, {9'd0, 4'b1111});
      step();
      check("post_rst_lit", {9'd0, o_an_a}, {9'd0, 4'b1110});
      repeat (40) step();

      // Randomised loads at arbitrary scan phases.
      for (int r = 0; r < 60; r++) begin
         i_value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         i_dp    = 4'($urandom_range(0, 15));
         i_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         i_load  = 1'b1;
         repeat ($urandom_range(1, 2)) step();
         i_load  = 1'b0;
         repeat ($urandom_range(1, 40)) step();
      end

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/drv_segment_hex_mux.md
DRV_SEGMENT_HEX_MUX -- requirements
Module: drv_segment_hex_mux

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot, at least 4.
REQ-003 Parameter GHOST_CYC, default 2: anti-ghost dark cycles at the start of each slot; SHALL be less than SCAN_DIV.
REQ-004 Parameter LZ_SUPPRESS, default 0: 1 enables leading-zero suppression.
REQ-005 Port i_clk, input, 1: the single clock; all logic SHALL be rising-edge.
REQ-006 Port i_rst, input, 1: reset, asynchronous assertion, active-high.
REQ-007 Port i_value, input, 4*DIGITS: nibble k is the hex digit for position k; k=0 is the rightmost digit.
REQ-008 Port i_dp, input, DIGITS: per-digit decimal point request, 1 lights the point.
REQ-009 Port i_blank, input, DIGITS: per-digit forced blank, 1 blanks the digit.
REQ-010 Port i_load, input, 1: capture strobe for i_value, i_dp and i_blank.
REQ-011 Port o_drv_sgmnt, output, 7: segment cathodes, active-low; bit0=a, bit1=b … bit6=g.
REQ-012 Port o_drv_dp, output, 1: decimal point cathode, active-low.
REQ-013 Port o_drv_anode, output, DIGITS: digit enables, active-low, at most one low at any time.
REQ-014 Port o_frame, output, 1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Function
REQ-015 i_load=1 at a rising edge SHALL capture i_value, i_dp and i_blank into shadow registers; with i_load=0 the shadows hold.
REQ-016 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; at the terminal count the digit index SHALL advance by one, wrapping from DIGITS-1 to 0.
REQ-017 o_frame SHALL be 1 for exactly the one cycle following the index wrap to 0.
REQ-018 While prescaler < GHOST_CYC, all anodes SHALL be high and all cathodes high.
REQ-019 Otherwise, the anode of the current index SHALL be low and the cathodes SHALL show that digit's decoded shadow value.
REQ-020 Hex decode, active-low g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 A blanked digit SHALL drive o_drv_sgmnt=1111111 and o_drv_dp=1; its anode SHALL still follow the scan.
REQ-022 With LZ_SUPPRESS=1, digit k>0 SHALL be blanked when it and all higher digits are 0; digit 0 SHALL never be suppressed.
REQ-023 o_drv_dp SHALL be low only when the digit is active, i_dp shadow=1 and the digit is not forced blank; zero suppression SHALL NOT hide the point.
REQ-024 All outputs SHALL be registered, with one cycle of latency from prescaler/index state to pins.
REQ-025 A load in the same cycle as a digit switch SHALL take effect: the new slot shows the new value from its first lit cycle.
REQ-026 A load mid-slot SHALL change the cathodes on the next cycle without disturbing the scan timing.

Reset
REQ-027 While i_rst=1: prescaler=0, index=0, value shadow=0, dp shadow=0, blank shadow all ones.
REQ-028 While i_rst=1: o_drv_anode all ones, o_drv_sgmnt=1111111, o_drv_dp=1, o_frame=0.
REQ-029 Reset mid-slot SHALL darken the display immediately, without waiting for a clock.
REQ-030 After release, the first slot SHALL begin at index 0 with the GHOST_CYC dark interval.

Structure
REQ-031 Package pkg_segment SHALL hold the 16-entry encoding constant table, the blank code 1111111 and the segment-vector typedef.
REQ-032 Hex-to-segment decoding SHALL be a sub-module, drv_segment_hex_dec (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.
REQ-033 DIGITS=1 SHALL be legal: the index stays at 0 and o_frame pulses once per SCAN_DIV.

Verification (DIGITS=4, SCAN_DIV=8, GHOST_CYC=2)
REQ-034 Reset, then load value 0x1234, blank 0000 -> anodes cycle 1110,1101,1011,0111, each low 6 of 8 cycles; cathodes show 4,3,2,1 codes; o_frame every 32 cycles.
REQ-035 Load 0x00A0 with LZ_SUPPRESS=1 -> digits 3 and 2 dark; digit 1 shows 0001000; digit 0 shows 1000000.
REQ-036 Load dp=0100, blank=0100 -> digit 2 shows cathodes 1111111 and dp 1; all other digits have dp=1.
REQ-037 Load 0xFFFF on the terminal prescaler cycle of digit 0 -> digit 1 shows 0001110 on its first lit cycle.
REQ-038 Assert i_rst mid-slot of digit 2 -> all outputs inactive immediately; after release, digit 0 lights after a 2-cycle dark interval.
